walk_stim_checker: RTL
======================

WALK_STIM_CHECKER -- requirements
Module: walk_stim_checker

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the width of the drive and response vectors, legal range 4 to 32.
REQ-002 Parameter SETTLE, default 1, SHALL set the number of cycles each vector is held before the response is sampled, legal range 1 to 15.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 start  input  1  SHALL begin a run when sampled high in IDLE.
REQ-006 a  output  WIDTH  SHALL be the first operand driven to the gate array under test.
REQ-007 b  output  WIDTH  SHALL be the second operand driven to the gate array under test.
REQ-008 out_in  input  WIDTH  SHALL be the response returned from the gate array under test.
REQ-009 busy  output  1  SHALL be high in every state except IDLE.
REQ-010 done  output  1  SHALL be a one-cycle pulse marking the end of a run.
REQ-011 pass  output  1  SHALL report whether the last completed run had zero mismatches.
REQ-012 err_count  output  8  SHALL hold the saturating mismatch count for the current or last run.

Function
REQ-013 FSM states SHALL be IDLE, SETTLE, CHECK and DONE.
REQ-014 IDLE with start=1 SHALL load a=1, b=1<<(WIDTH-1), err_count=0, pass=0, and the settle counter=SETTLE, then go to SETTLE.
REQ-015 SETTLE SHALL decrement the counter each cycle and go to CHECK when the counter reaches 1.
REQ-016 CHECK SHALL last exactly one cycle and compare out_in against a|b; any bit differing, including X or Z in simulation, SHALL count as a mismatch.
REQ-017 A mismatch SHALL increment err_count, saturating at 255.
REQ-018 Vector advance after CHECK: if b!=1, b SHALL shift right one bit.
REQ-019 Vector advance after CHECK: if b==1 and a!=1<<(WIDTH-2), a SHALL shift left one bit and b SHALL reload to 1<<(WIDTH-1).
REQ-020 Vector advance after CHECK: if b==1 and a==1<<(WIDTH-2), the FSM SHALL go to DONE.
REQ-021 Each advance except the final one SHALL reload the settle counter and return to SETTLE.
REQ-022 One run SHALL cover (WIDTH-1)*WIDTH vectors, which is 240 at default, with each vector held SETTLE+1 cycles.
REQ-023 Start-to-done latency SHALL be N*(SETTLE+1)+1 cycles, where N is the vector count.
REQ-024 DONE SHALL assert done for one cycle, set pass=(err_count==0), and return to IDLE.
REQ-025 a, b, err_count and pass SHALL hold their values in IDLE until the next start.
REQ-026 start SHALL be ignored while busy=1.
REQ-027 start and reset high in the same cycle SHALL resolve with reset winning.

Reset
REQ-028 reset SHALL force state=IDLE, a=0, b=0, busy=0, done=0, pass=0, err_count=0 and the settle counter to 0.
REQ-029 Reset asserted mid-run SHALL abort the run with no done pulse.
REQ-030 The first start after reset is released SHALL begin a fresh run from a=1.

Configuration
REQ-031 With WALK_STIM_FIRST_FAIL_EN defined, outputs fail_valid (1), fail_a (WIDTH), fail_b (WIDTH) and fail_out (WIDTH) SHALL exist.
REQ-032 With the macro defined, the first mismatch of a run SHALL capture a, b and out_in and set fail_valid.
REQ-033 With the macro defined, later mismatches SHALL NOT overwrite the capture.
REQ-034 With the macro defined, start and reset SHALL clear all four fail outputs to 0.
REQ-035 Without the macro, those four ports and their registers SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-036 Ideal OR model (out_in=a|b), defaults: pulse start -> done after 481 cycles, pass=1, err_count=0.
REQ-037 out_in bit 3 stuck at 0, defaults -> err_count=30, pass=0; with macro: fail_a=0x0001, fail_b=0x0008, fail_out=0x0001.
REQ-038 out_in tied to 0x0000 -> err_count=240, pass=0.
REQ-039 Reset asserted 100 cycles after start -> next cycle busy=0, a=0, b=0, err_count=0, and no done pulse.
REQ-040 start re-pulsed at cycles 5 and 50 of a run -> no restart and done still at cycle 481; SETTLE=3 ideal run -> done at cycle 961, pass=1.

Source files
------------

// File: rtl/walk_stim_checker.sv
// walk_stim_checker: walking-ones stimulus generator and response checker for a
// bitwise-OR gate array. Operand a walks a single one from bit 0 up to bit WIDTH-2;
// for each a, operand b walks a single one from bit WIDTH-1 down to bit 0. Each
// vector is held SETTLE cycles and then checked for one cycle against a|b, giving
// (WIDTH-1)*WIDTH vectors per run. A saturating 8-bit count records mismatches.
//
// Optional build macro WALK_STIM_FIRST_FAIL_EN adds fail_valid/fail_a/fail_b/fail_out,
// which capture the operands and response of the first mismatch of a run.

module walk_stim_checker #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] out_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count
`ifdef WALK_STIM_FIRST_FAIL_EN
  ,
  output logic             fail_valid,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [WIDTH-1:0] fail_out
`endif
);

  // Vector constants: a starts at bit 0 and stops at bit WIDTH-2, b restarts at the MSB.
  localparam logic [WIDTH-1:0] VecOne  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] VecTop  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] VecLast = {2'b01, {(WIDTH-2){1'b0}}};
  localparam logic [3:0]       SettleLoad = 4'(SETTLE);

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StCheck,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [7:0]       err_q, err_d;
  logic             pass_q, pass_d;
  logic             mismatch;

`ifdef WALK_STIM_FIRST_FAIL_EN
  logic             fail_valid_q, fail_valid_d;
  logic [WIDTH-1:0] fail_a_q, fail_a_d;
  logic [WIDTH-1:0] fail_b_q, fail_b_d;
  logic [WIDTH-1:0] fail_out_q, fail_out_d;
`endif

  // Case inequality so that X or Z on any response bit counts as a mismatch in simulation.
  assign mismatch = (out_in !== (a_q | b_q));

  // Next-state, vector advance, error accounting and status outputs.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    pass_d  = pass_q;
    done    = 1'b0;
    busy    = (state_q != StIdle);
`ifdef WALK_STIM_FIRST_FAIL_EN
    fail_valid_d = fail_valid_q;
    fail_a_d     = fail_a_q;
    fail_b_d     = fail_b_q;
    fail_out_d   = fail_out_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = VecOne;
          b_d     = VecTop;
          err_d   = 8'd0;
          pass_d  = 1'b0;
          cnt_d   = SettleLoad;
          state_d = StSettle;
`ifdef WALK_STIM_FIRST_FAIL_EN
          fail_valid_d = 1'b0;
          fail_a_d     = '0;
          fail_b_d     = '0;
          fail_out_d   = '0;
`endif
        end
      end

      StSettle: begin
        // Counter holds 1 in the last settle cycle; never let it wrap below zero.
        cnt_d = (cnt_q != 4'd0) ? (cnt_q - 4'd1) : 4'd0;
        if (cnt_q <= 4'd1) begin
          state_d = StCheck;
        end
      end

      StCheck: begin
        if (mismatch) begin
          if (err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
          end
`ifdef WALK_STIM_FIRST_FAIL_EN
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_a_d     = a_q;
            fail_b_d     = b_q;
            fail_out_d   = out_in;
          end
`endif
        end

        if (b_q != VecOne) begin
          b_d     = b_q >> 1;
          cnt_d   = SettleLoad;
          state_d = StSettle;
        end else if (a_q != VecLast) begin
          a_d     = a_q << 1;
          b_d     = VecTop;
          cnt_d   = SettleLoad;
          state_d = StSettle;
        end else begin
          // Final vector: a and b keep their last values through DONE and IDLE.
          state_d = StDone;
        end
      end

      StDone: begin
        done    = 1'b1;
        pass_d  = (err_q == 8'd0);
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register with synchronous active-high reset; reset beats a concurrent start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= 4'd0;
      err_q   <= 8'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
    end
  end

`ifdef WALK_STIM_FIRST_FAIL_EN
  // First-failure capture registers, cleared by reset and by each new run.
  always_ff @(posedge clk) begin
    if (reset) begin
      fail_valid_q <= 1'b0;
      fail_a_q     <= '0;
      fail_b_q     <= '0;
      fail_out_q   <= '0;
    end else begin
      fail_valid_q <= fail_valid_d;
      fail_a_q     <= fail_a_d;
      fail_b_q     <= fail_b_d;
      fail_out_q   <= fail_out_d;
    end
  end

  assign fail_valid = fail_valid_q;
  assign fail_a     = fail_a_q;
  assign fail_b     = fail_b_q;
  assign fail_out   = fail_out_q;
`endif

  assign a         = a_q;
  assign b         = b_q;
  assign pass      = pass_q;
  assign err_count = err_q;

`ifndef SYNTHESIS
  // done is a single-cycle pulse.
  a_done_pulse: assert property (@(posedge clk) disable iff (reset) done |=> !done);

  // While running, both operands always carry exactly one set bit.
  a_onehot_vec: assert property (@(posedge clk) disable iff (reset)
    busy |-> ($onehot(a_q) && $onehot(b_q)));

  // The settle counter is never zero while settling.
  a_cnt_live: assert property (@(posedge clk) disable iff (reset)
    (state_q == StSettle) |-> (cnt_q != 4'd0));

  // A saturated count stays saturated for the rest of the run.
  a_err_sat: assert property (@(posedge clk) disable iff (reset)
    (busy && err_q == 8'hFF) |=> (err_q == 8'hFF || !busy || start));
`endif

endmodule
